// File: rtl/apb_gpio_cmd_sequencer_pkg.sv
// Shared opcode/state types, GPIO register map and PWDATA field layout for the command sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package gpio_seq_pkg;

   // Pin-level command opcodes seen on req_op_i
   typedef enum logic [2:0] {
      OP_SET  = 3'd0,
      OP_CLR  = 3'd1,
      OP_TOG  = 3'd2,
      OP_DIR  = 3'd3,
      OP_INT  = 3'd4,
      OP_STAT = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } gpio_op_e;

   // Sequencer FSM states; SETUP/ACCESS follow the APB phases directly
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } seq_state_e;

   // GPIO slave register offsets (the slave decodes the same values)
   localparam logic [11:0] GPIO_REG_SET    = 12'h000;
   localparam logic [11:0] GPIO_REG_CLR    = 12'h004;
   localparam logic [11:0] GPIO_REG_TOG    = 12'h008;
   localparam logic [11:0] GPIO_REG_SETSEL = 12'h030;
   localparam logic [11:0] GPIO_REG_RDSTAT = 12'h034;
   localparam logic [11:0] GPIO_REG_DIR    = 12'h038;
   localparam logic [11:0] GPIO_REG_INT    = 12'h03C;

   // PWDATA field positions on top of the pin number in the low bits
   localparam int DIR_LSB      = 24;
   localparam int INT_TYPE_LSB = 17;
   localparam int INT_EN_BIT   = 16;

   function automatic logic op_legal(gpio_op_e op);
      return (op != OP_RSV6) && (op != OP_RSV7);
   endfunction

   // Address of the first (for STAT: SETSEL) transaction of a command
   function automatic logic [11:0] op_addr(gpio_op_e op);
      logic [11:0] a;
      a = 12'h000;
      case (op)
         OP_SET:  a = GPIO_REG_SET;
         OP_CLR:  a = GPIO_REG_CLR;
         OP_TOG:  a = GPIO_REG_TOG;
         OP_DIR:  a = GPIO_REG_DIR;
         OP_INT:  a = GPIO_REG_INT;
         OP_STAT: a = GPIO_REG_SETSEL;
         default: a = 12'h000;
      endcase
      return a;
   endfunction

   // Opcode-specific PWDATA bits; the pin field is OR-ed in by the caller
   function automatic logic [31:0] op_field(gpio_op_e op, logic [3:0] arg);
      logic [31:0] w;
      w = 32'h0;
      if (op == OP_DIR) begin
         w[DIR_LSB +: 2] = arg[1:0];
      end else if (op == OP_INT) begin
         w[INT_TYPE_LSB +: 3] = arg[3:1];
         w[INT_EN_BIT]        = arg[0];
      end
      return w;
   endfunction

endpackage

// File: rtl/apb_gpio_cmd_sequencer_arb.sv
// Round-robin arbiter: picks the first active request strictly after the pointer position.
// Latency: combinational, same cycle.
// Backpressure: none; the parent decides when a grant is consumed and moves the pointer.
module gpio_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
   output logic                     gnt_vld_o
);

   localparam int IDX_W = $clog2(N_REQ);

   // Rotating priority scan starting one past the last winner
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         int cand;
         cand = (int'(ptr_i) + k) % N_REQ;
         if (!gnt_vld_o && req_i[cand]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = IDX_W'(cand);
         end
      end
      if (gnt_vld_o) begin
         gnt_o[gnt_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_gpio_cmd_sequencer.sv
// Shares one APB GPIO slave between N_REQ requesters: RR-arbitrated pin commands become APB transactions.
// Latency (PREADY=1): write rsp at accept+3, STAT rsp at accept+5, illegal op rsp at accept+1.
// Backpressure: one command in flight, ready only in IDLE; responses cannot be stalled; watchdog bounds PREADY waits.
module apb_gpio_cmd_sequencer
   import gpio_seq_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int N_GPIO         = 32,
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT        = 255,
   localparam int PIN_W         = $clog2(N_GPIO)
) (
   input  logic                            HCLK,
   input  logic                            HRESETn,
   input  logic [N_REQ-1:0]                req_valid_i,
   output logic [N_REQ-1:0]                req_ready_o,
   input  logic [N_REQ-1:0][2:0]           req_op_i,
   input  logic [N_REQ-1:0][PIN_W-1:0]     req_pin_i,
   input  logic [N_REQ-1:0][3:0]           req_arg_i,
   output logic [N_REQ-1:0]                rsp_valid_o,
   output logic [31:0]                     rsp_rdata_o,
   output logic                            rsp_err_o,
   output logic                            busy_o,
   output logic [APB_ADDR_WIDTH-1:0]       PADDR,
   output logic [31:0]                     PWDATA,
   output logic                            PWRITE,
   output logic                            PSEL,
   output logic                            PENABLE,
   input  logic [31:0]                     PRDATA,
   input  logic                            PREADY,
   input  logic                            PSLVERR
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit WD_EN = (TIMEOUT > 0);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   seq_state_e                state_q, state_d;
   logic [IDX_W-1:0]          ptr_q, ptr_d;
   logic [IDX_W-1:0]          gnt_q, gnt_d;
   gpio_op_e                  op_q, op_d;
   logic                      phase_q, phase_d;
   logic                      err_acc_q, err_acc_d;
   logic [WD_W-1:0]           wdog_q, wdog_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic [N_REQ-1:0]          rsp_valid_q, rsp_valid_d;
   logic                      rsp_err_q, rsp_err_d;
   logic [31:0]               rsp_rdata_q, rsp_rdata_d;

   logic [N_REQ-1:0]          arb_gnt;
   logic [IDX_W-1:0]          arb_idx;
   logic                      arb_vld;
   gpio_op_e                  in_op;
   logic [31:0]               in_wdata;
   logic                      txn_err;

   gpio_rr_arbiter #(
      .N_REQ     (N_REQ)
   ) u_arb (
      .req_i     (req_valid_i),
      .ptr_i     (ptr_q),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx),
      .gnt_vld_o (arb_vld)
   );

   // Ready is a one-cycle grant pulse, only while no command is in flight
   assign req_ready_o = (state_q == ST_IDLE) ? arb_gnt : '0;
   assign busy_o      = (state_q != ST_IDLE);

   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PWRITE      = pwrite_q;
   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;

   // Decode the winning requester's command into its first-transaction write data
   always_comb begin
      in_op    = gpio_op_e'(req_op_i[arb_idx]);
      in_wdata = 32'(req_pin_i[arb_idx]) | op_field(in_op, req_arg_i[arb_idx]);
   end

   // Sequencer FSM: next state plus next values of every registered APB/response output
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      op_d        = op_q;
      phase_d     = phase_q;
      err_acc_d   = err_acc_q;
      wdog_d      = '0;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      txn_err     = err_acc_q | PSLVERR;

      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               ptr_d     = arb_idx;
               gnt_d     = arb_idx;
               op_d      = in_op;
               phase_d   = 1'b0;
               err_acc_d = 1'b0;
               if (op_legal(in_op)) begin
                  state_d   = ST_SETUP;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  paddr_d   = APB_ADDR_WIDTH'(op_addr(in_op));
                  pwdata_d  = in_wdata;
                  pwrite_d  = 1'b1;
               end else begin
                  // Illegal opcodes never touch the bus
                  state_d              = ST_RESP;
                  rsp_valid_d[arb_idx] = 1'b1;
                  rsp_err_d            = 1'b1;
               end
            end
         end

         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end

         ST_ACCESS: begin
            if (PREADY) begin
               if ((op_q == OP_STAT) && !phase_q) begin
                  // SETSEL done; follow with the RDSTAT read
                  state_d   = ST_SETUP;
                  phase_d   = 1'b1;
                  err_acc_d = txn_err;
                  penable_d = 1'b0;
                  paddr_d   = APB_ADDR_WIDTH'(GPIO_REG_RDSTAT);
                  pwdata_d  = '0;
                  pwrite_d  = 1'b0;
               end else begin
                  state_d            = ST_RESP;
                  psel_d             = 1'b0;
                  penable_d          = 1'b0;
                  paddr_d            = '0;
                  pwdata_d           = '0;
                  pwrite_d           = 1'b0;
                  rsp_valid_d[gnt_q] = 1'b1;
                  rsp_err_d          = txn_err;
                  rsp_rdata_d        = (op_q == OP_STAT) ? PRDATA : 32'h0;
               end
            end else if (WD_EN && (wdog_q == WD_LAST)) begin
               // Slave hung: abandon the command, skip any remaining transaction
               state_d            = ST_RESP;
               psel_d             = 1'b0;
               penable_d          = 1'b0;
               paddr_d            = '0;
               pwdata_d           = '0;
               pwrite_d           = 1'b0;
               rsp_valid_d[gnt_q] = 1'b1;
               rsp_err_d          = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, command context and registered outputs; reset drops the bus and any in-flight command
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         ptr_q       <= IDX_W'(N_REQ - 1);
         gnt_q       <= '0;
         op_q        <= OP_SET;
         phase_q     <= 1'b0;
         err_acc_q   <= 1'b0;
         wdog_q      <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         op_q        <= op_d;
         phase_q     <= phase_d;
         err_acc_q   <= err_acc_d;
         wdog_q      <= wdog_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule
